// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Brief    : W-bit add/subtract sequenced LSB-first over one shared external
//            4-bit carry-propagate adder, with start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 c_in,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 ovf,
    output logic [3:0]           cpa_a,
    output logic [3:0]           cpa_b,
    output logic                 cpa_cin,
    input  logic [3:0]           cpa_s,
    input  logic                 cpa_cout
);

    localparam int              W          = 4 * NIBBLES;
    localparam int              IDXW       = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_c_out;
    logic            r_ovf;
    logic            w_accept;
    logic            w_last;
    logic [3:0]      w_nib_a;
    logic [3:0]      w_nib_b;

    assign w_last = (r_idx == C_LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Select the active nibble of each operand register.
    always_comb begin
        w_nib_a = 4'd0;
        w_nib_b = 4'd0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDXW'(n)) begin
                w_nib_a = r_a[4*n +: 4];
                w_nib_b = r_b[4*n +: 4];
            end
        end
    end

    assign cpa_a   = busy ? w_nib_a : 4'd0;
    assign cpa_b   = busy ? w_nib_b : 4'd0;
    assign cpa_cin = busy ? r_carry : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction runs as A + ~B + 1.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (r_idx == IDXW'(n)) begin
                    r_sum[4*n +: 4] <= cpa_s;
                end
            end
            r_carry <= cpa_cout;
            if (w_last) begin
                r_c_out <= cpa_cout;
                r_ovf   <= (r_a[W-1] == r_b[W-1]) && (cpa_s[3] != r_a[W-1]);
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Self-checking bench with a CPA model and arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic         c_in  = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic [3:0]   cpa_a;
    logic [3:0]   cpa_b;
    logic         cpa_cin;
    logic [3:0]   cpa_s;
    logic         cpa_cout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign {cpa_cout, cpa_s} = {1'b0, cpa_a} + {1'b0, cpa_b} + {4'd0, cpa_cin};

    nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .c_in     (c_in),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .ovf      (ovf),
        .cpa_a    (cpa_a),
        .cpa_b    (cpa_b),
        .cpa_cin  (cpa_cin),
        .cpa_s    (cpa_s),
        .cpa_cout (cpa_cout)
    );

    // Returns {ovf, c_out, sum} from plain W-bit arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s, input logic ci);
        logic [W:0]   full;
        logic [W-1:0] ny;
        logic         o;
        if (s) begin
            ny   = ~y;
            full = {1'b0, x} + {1'b0, ny} + {{W{1'b0}}, 1'b1};
            o    = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            o    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        end
        return {o, full};
    endfunction

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xs, input logic xc, input string nm);
        logic [W+1:0] exp;
        logic [W-1:0] bop;
        logic [3:0]   ea;
        logic [3:0]   eb;
        int           k;
        exp = model(xa, xb, xs, xc);
        bop = xs ? ~xb : xb;
        @(negedge clk);
        a = xa; b = xb; sub = xs; c_in = xc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 3 * NIBBLES) begin
            ea = 4'(xa >> (4 * k));
            eb = 4'(bop >> (4 * k));
            total++;
            if (busy !== 1'b1 || cpa_a !== ea || cpa_b !== eb) begin
                bad++;
                $display("FAIL %s run k=%0d busy/cpa_a/cpa_b got %b/%h/%h want 1/%h/%h",
                         nm, k, busy, cpa_a, cpa_b, ea, eb);
            end
            if (k == 0) begin
                total++;
                if (cpa_cin !== (xs | xc)) begin
                    bad++;
                    $display("FAIL %s cpa_cin got %b want %b", nm, cpa_cin, xs | xc);
                end
            end
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k != NIBBLES) begin
            bad++;
            $display("FAIL %s latency got %0d want %0d", nm, k, NIBBLES);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || {ovf, c_out, sum} !== exp) begin
            bad++;
            $display("FAIL %s result done=%b busy=%b ovf/cout/sum got %b/%b/%h want %b/%b/%h",
                     nm, done, busy, ovf, c_out, sum, exp[W+1], exp[W], exp[W-1:0]);
        end
        total++;
        if (cpa_a !== 4'd0 || cpa_b !== 4'd0 || cpa_cin !== 1'b0) begin
            bad++;
            $display("FAIL %s cpa idle drive got %h/%h/%b want 0/0/0", nm, cpa_a, cpa_b, cpa_cin);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || {ovf, c_out, sum} !== exp) begin
            bad++;
            $display("FAIL %s hold done=%b busy=%b ovf/cout/sum got %b/%b/%h want 0/0/%b/%b/%h",
                     nm, done, busy, ovf, c_out, sum, exp[W+1], exp[W], exp[W-1:0]);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0 ||
            cpa_a !== 4'd0 || cpa_b !== 4'd0 || cpa_cin !== 1'b0) begin
            bad++;
            $display("FAIL reset_values busy=%b done=%b sum=%h cout=%b ovf=%b cpa=%h/%h/%b want all 0",
                     busy, done, sum, c_out, ovf, cpa_a, cpa_b, cpa_cin);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || sum !== '0) begin
                bad++;
                $display("FAIL reset_idle busy=%b done=%b sum=%h want 0/0/0", busy, done, sum);
            end
        end
    endtask

    task automatic test_directed();
        do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, "add_basic");
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
        do_op(16'h00FF, 16'h0000, 1'b0, 1'b1, "add_cin");
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, "sub_neg");
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub_ovf");
        do_op(16'h1234, 16'h1234, 1'b1, 1'b1, "sub_equal");
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 8 == 0) ra = 16'h8000 | ra[3:0];
            if (i % 8 == 1) rb = 16'h7FFF;
            do_op(ra, rb, 1'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        int k;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        while (done !== 1'b1 && k < 3 * NIBBLES) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k != NIBBLES || sum !== 16'h0002) begin
            bad++;
            $display("FAIL b2b_first latency=%0d sum=%h want %0d/0002", k, sum, NIBBLES);
        end
        a = 16'h0002; b = 16'h0003;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || sum !== 16'h0000) begin
            bad++;
            $display("FAIL b2b_restart busy=%b done=%b sum=%h want 1/0/0000", busy, done, sum);
        end
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 3 * NIBBLES) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k != NIBBLES || sum !== 16'h0005 || c_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second latency=%0d sum=%h cout=%b want %0d/0005/0", k, sum, c_out, NIBBLES);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_during_run();
        int k;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'($urandom); b = 16'($urandom); sub = 1'b1; c_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 2;
        while (done !== 1'b1 && k < 3 * NIBBLES) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k != NIBBLES || sum !== 16'h3333 || c_out !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL start_in_run latency=%0d sum=%h cout=%b ovf=%b want %0d/3333/0/0",
                     k, sum, c_out, ovf, NIBBLES);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        a = 16'h5678; b = 16'h1111; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || c_out !== 1'b0 || ovf !== 1'b0 ||
            cpa_a !== 4'd0 || cpa_b !== 4'd0 || cpa_cin !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_op busy=%b done=%b sum=%h cout=%b ovf=%b cpa=%h/%h/%b want all 0",
                     busy, done, sum, c_out, ovf, cpa_a, cpa_b, cpa_cin);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_no_done done=%b busy=%b want 0/0", done, busy);
            end
        end
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_during_run();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs a W-bit add/subtract by time-multiplexing one external 4-bit carry-propagate adder (CPA: a[3:0], b[3:0], c_in -> s[3:0], c_out) over NIBBLES cycles, LSB nibble first. The block owns the operand and carry registers, drives the shared CPA's inputs, captures its outputs, and presents a start/busy/done handshake to the requester. The CPA stays outside the block and is purely combinational; its full ripple delay must fit within one clk period.

Parameters:
NIBBLES, 4, number of 4-bit slices; word width W = 4*NIBBLES (16 by default); legal range 2..8

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE or DONE
sub  in  1  0 = a+b+c_in, 1 = a-b (two's complement; c_in ignored)
c_in  in  1  carry into bit 0 for add
a  in  W  operand A, sampled on accepted start
b  in  W  operand B, sampled on accepted start
busy  out  1  high while the operation is in progress (RUN)
done  out  1  one-cycle pulse, result valid
sum  out  W  result register
c_out  out  1  carry out of bit W-1 (add: unsigned carry; sub: 1 = no borrow)
ovf  out  1  signed overflow
cpa_a  out  4  to the CPA a input
cpa_b  out  4  to the CPA b input
cpa_cin  out  1  to the CPA c_in input
cpa_s  in  4  from the CPA s output
cpa_cout  in  1  from the CPA c_out output

Behaviour:
- States: IDLE, RUN, DONE. Nibble index idx is ceil(log2(NIBBLES)) bits wide. Internal registers: A_r, B_r, carry_r, sign bits.
- Reset (asynchronous, at any time including mid-RUN): state=IDLE, idx=0, busy=0, done=0, sum=0, c_out=0, ovf=0, A_r=B_r=0, carry_r=0. The CPA drive outputs go to 0.
- Accepted start: start=1 at a rising edge while in IDLE or DONE. On that edge:
  - A_r<=a; B_r<=sub ? ~b : b; carry_r<=sub ? 1 : c_in.
  - sum<=0, c_out<=0, ovf<=0.
  - idx<=0; state<=RUN.
- start in RUN is ignored, with no effect on the in-flight operation.
- RUN, combinational drive:
  - cpa_a = A_r[4*idx+3:4*idx]
  - cpa_b = B_r[4*idx+3:4*idx]
  - cpa_cin = carry_r
- RUN, each edge:
  - sum[4*idx+3:4*idx] <= cpa_s; carry_r <= cpa_cout.
  - If idx == NIBBLES-1: state<=DONE; c_out<=cpa_cout; ovf<=(A_r[W-1]==B_r[W-1]) && (cpa_s[3]!=A_r[W-1]).
  - Otherwise idx<=idx+1.
- IDLE and DONE: cpa_a=0, cpa_b=0, cpa_cin=0.
- Outputs per state:
  - busy = (state==RUN).
  - done = (state==DONE). DONE lasts exactly one cycle and then goes to IDLE, unless start is accepted in that cycle, in which case it goes straight to RUN.
- Latency: start accepted at edge E0 -> busy high from E0 to E_NIBBLES. done high for the cycle after edge E_NIBBLES, i.e. NIBBLES+1 edges from accept to done falling.
- Result persistence: sum, c_out and ovf hold until the next accepted start or rst. sum is not a valid result while busy=1.
- Arithmetic: modulo 2^W. The sub path is A + ~B + 1, so c_out=1 means A >= B unsigned.

Test Plan:
- Reset values: assert rst mid-cycle with no clock edge -> all outputs 0 immediately; deassert rst, start=0 -> stays IDLE, busy=0.
- Add: a=0x1234, b=0x0FFF, sub=0, c_in=0 -> busy for 4 cycles; cpa_a sequence 4,3,2,1; done pulse 1 cycle; sum=0x2233, c_out=0, ovf=0.
- Carry/wrap: a=0xFFFF, b=0x0001 -> sum=0x0000, c_out=1, ovf=0. Also a=0x00FF, b=0x0000, c_in=1 -> sum=0x0100.
- Subtract and overflow:
  - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0, ovf=0.
  - a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, c_out=0, ovf=1.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Handshake edges:
  - Hold start high continuously with a=1, b=1 -> a second start is accepted in the DONE cycle, giving back-to-back operations with no IDLE gap.
  - Change a/b and pulse start during RUN -> ignored; result comes from the original operands.
- Reset mid-op: assert rst after the 2nd RUN edge -> busy=0, sum=0, no done pulse. A new start then completes normally (0x0003+0x0004=0x0007).
